mouse_paint_writer: RTL and testbench
=====================================

// Module: mouse_paint_writer
// PURPOSE
// Converts decoded PS/2 mouse packets into framebuffer writes for led_panel_4k.
// Tracks a cursor on the 64x64 panel and paints the active colour (left button) or erases (right button).
// Drives the panel memory write port (wr0/address/wdata) and sits between the PS/2 packet decoder and the panel driver.
// Clears the framebuffer after reset and on request.
// PARAMETERS
// ADDR_W       12  framebuffer address width, {y,x}
// DATA_W       12  pixel width, RGB444 {R[11:8],G[7:4],B[3:0]}
// COORD_W      6   bits per axis (64x64 panel)
// SPEED_SHIFT  0   arithmetic right shift applied to dx/dy before accumulation
// PORTS
// clk                input   1   system clock
// rst                input   1   asynchronous, active-high reset
// mouse_data_valid   input   1   one-cycle pulse: packet fields valid
// mouse_dx           input   9   signed two's-complement X movement
// mouse_dy           input   9   signed two's-complement Y movement, +ve = up
// mouse_btn          input   3   {middle,right,left}, 1 = pressed
// clear_req          input   1   one-cycle pulse: clear framebuffer (honoured in IDLE only)
// wr0                output  1   framebuffer write strobe, one cycle per word
// address            output  12  write address = {cursor_y,cursor_x} or clear counter
// wdata              output  12  write data
// busy               output  1   high in any state except IDLE
// cursor_x           output  6   current column
// cursor_y           output  6   current row, 0 = top
// overflow           output  1   sticky: packet arrived while busy
// BEHAVIOUR
// - Reset (async): state=CLEAR, clr_cnt=0, wr0=0, address=0, wdata=0, busy=1, cursor=(32,32),
//   colour index=0, prev_middle=0, overflow=0.
// - FSM: CLEAR -> IDLE -> UPDATE -> WRITE -> IDLE.
// - CLEAR: wr0=1, address=clr_cnt, wdata=0 on each of 4096 consecutive cycles, clr_cnt 0..4095.
//   After the 4095 write, go to IDLE. Packets received in CLEAR are dropped and set overflow.
//   clear_req in IDLE: go to CLEAR with clr_cnt=0 and overflow cleared.
// - IDLE + mouse_data_valid (cycle N): latch packet. If both valid and clear_req, valid wins; clear_req is dropped.
// - UPDATE (N+1):
//   x' = x + (dx>>>SPEED_SHIFT); y' = y - (dy>>>SPEED_SHIFT), computed in 11-bit signed.
//   Clamp each axis to 0..63; no wrap-around.
//   Middle-button rising edge (packet middle=1, prev_middle=0): colour index +1 mod 8. Then prev_middle <= middle.
// - WRITE (N+2): if right=1, wr0=1 and wdata=0 (right has priority over left).
//   Else if left=1, wr0=1 and wdata=palette[idx]. Else wr0=0.
//   address={y',x'}, using the updated position. Return to IDLE at N+3.
// - Palette: 0 FFF, 1 F00, 2 0F0, 3 00F, 4 FF0, 5 0FF, 6 F0F, 7 F80.
// - busy=0 only in IDLE. Any mouse_data_valid while busy sets overflow; that packet is discarded.
// - wr0 is never high outside CLEAR/WRITE. address/wdata hold their last value when wr0=0.
// - Minimum packet spacing for no loss: 3 cycles.
// TESTING
// 1. Release rst -> exactly 4096 wr0 pulses, addr 0..4095, wdata=0; busy falls the cycle after the last write.
// 2. Post-clear packet dx=+5, dy=+3, btn=001 -> single write addr=29*64+37=1893, wdata=FFF, at N+2; cursor=(37,29).
// 3. dx=-100, dy=-100, btn=000 from (32,32) -> cursor=(0,63), no wr0.
//    Then dx=+255 -> x=63 (clamped).
// 4. Middle press (btn=100), then middle held (btn=101) -> second packet writes F00 (index 1), not 0F0.
//    btn=011 -> wdata=000.
// 5. Two valids 1 cycle apart -> second dropped, overflow=1.
//    clear_req -> overflow=0 and a full clear sweep runs.
// 6. Assert rst at clr_cnt=2000 -> outputs return to reset values immediately; after release, sweep restarts at address 0.

Source files
------------

// File: rtl/mouse_paint_writer.sv
// mouse_paint_writer: turns decoded PS/2 mouse packets into 64x64 framebuffer paint/erase writes
module mouse_paint_writer #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 12,
  parameter int COORD_W     = 6,
  parameter int SPEED_SHIFT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mouse_data_valid,
  input  logic [8:0]          mouse_dx,
  input  logic [8:0]          mouse_dy,
  input  logic [2:0]          mouse_btn,
  input  logic                clear_req,
  output logic                wr0,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W-1:0]   wdata,
  output logic                busy,
  output logic [COORD_W-1:0]  cursor_x,
  output logic [COORD_W-1:0]  cursor_y,
  output logic                overflow
);
  typedef enum logic [1:0] {CLEAR, IDLE, UPDATE, WRITE} state_t;
  localparam logic signed [10:0] MAXC = 11'((1 << COORD_W) - 1);
  localparam logic [DATA_W-1:0] PALETTE [8] = '{12'hFFF, 12'hF00, 12'h0F0, 12'h00F,
                                               12'hFF0, 12'h0FF, 12'hF0F, 12'hF80};
  state_t state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [8:0] dx_q, dy_q;
  logic [2:0] btn_q, idx, nidx;
  logic prev_middle;
  logic signed [10:0] dx_e, dy_e, x_sum, y_sum;
  logic [COORD_W-1:0] nx, ny;
  always_comb begin
    dx_e  = {{2{dx_q[8]}}, dx_q};
    dy_e  = {{2{dy_q[8]}}, dy_q};
    x_sum = $signed({{(11-COORD_W){1'b0}}, cursor_x}) + (dx_e >>> SPEED_SHIFT);
    y_sum = $signed({{(11-COORD_W){1'b0}}, cursor_y}) - (dy_e >>> SPEED_SHIFT);
    nx    = x_sum[10] ? '0 : x_sum > MAXC ? '1 : x_sum[COORD_W-1:0];
    ny    = y_sum[10] ? '0 : y_sum > MAXC ? '1 : y_sum[COORD_W-1:0];
    nidx  = idx + 3'(btn_q[2] & ~prev_middle);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= CLEAR;
      clr_cnt     <= '0;
      wr0         <= 1'b0;
      address     <= '0;
      wdata       <= '0;
      busy        <= 1'b1;
      cursor_x    <= COORD_W'(32);
      cursor_y    <= COORD_W'(32);
      idx         <= '0;
      prev_middle <= 1'b0;
      overflow    <= 1'b0;
      dx_q        <= '0;
      dy_q        <= '0;
      btn_q       <= '0;
    end else begin
      if (mouse_data_valid && busy) overflow <= 1'b1;
      case (state)
        CLEAR: begin
          // leave only once the final word has been presented for a full cycle
          if (wr0 && &address) begin
            state <= IDLE;
            busy  <= 1'b0;
            wr0   <= 1'b0;
          end else begin
            wr0     <= 1'b1;
            address <= clr_cnt;
            wdata   <= '0;
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (mouse_data_valid) begin
            dx_q  <= mouse_dx;
            dy_q  <= mouse_dy;
            btn_q <= mouse_btn;
            state <= UPDATE;
            busy  <= 1'b1;
          end else if (clear_req) begin
            clr_cnt  <= '0;
            overflow <= 1'b0;
            state    <= CLEAR;
            busy     <= 1'b1;
          end
        end
        UPDATE: begin
          cursor_x    <= nx;
          cursor_y    <= ny;
          idx         <= nidx;
          prev_middle <= btn_q[2];
          wr0         <= btn_q[1] | btn_q[0];
          if (btn_q[1] | btn_q[0]) begin
            address <= {ny, nx};
            wdata   <= btn_q[1] ? '0 : PALETTE[nidx];
          end
          state <= WRITE;
        end
        default: begin
          wr0   <= 1'b0;
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mouse_paint_writer.sv
// tb_mouse_paint_writer: randomized packets checked against a cursor/palette reference model
module tb_mouse_paint_writer;
  localparam int SS = 0;
  logic clk = 0, rst = 1;
  logic mouse_data_valid = 0, clear_req = 0;
  logic [8:0] mouse_dx = 0, mouse_dy = 0;
  logic [2:0] mouse_btn = 0;
  logic wr0, busy, overflow;
  logic [11:0] address, wdata;
  logic [5:0] cursor_x, cursor_y;
  int checks = 0, errors = 0;
  int ex, ey, eidx, laddr, ldata;
  logic epm, eov;
  logic [11:0] pal [8] = '{12'hFFF, 12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'h0FF, 12'hF0F, 12'hF80};

  mouse_paint_writer #(.SPEED_SHIFT(SS)) dut (
    .clk(clk), .rst(rst), .mouse_data_valid(mouse_data_valid), .mouse_dx(mouse_dx),
    .mouse_dy(mouse_dy), .mouse_btn(mouse_btn), .clear_req(clear_req), .wr0(wr0),
    .address(address), .wdata(wdata), .busy(busy), .cursor_x(cursor_x),
    .cursor_y(cursor_y), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int clamp(input int v);
    return v < 0 ? 0 : v > 63 ? 63 : v;
  endfunction

  // stop_at >= 0 abandons the sweep right after the write to that address
  task automatic sweep(input int stop_at);
    int n = 0, bad = 0, last = -10, cyc = 0;
    while (busy && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (wr0) begin
        if (address !== 12'(n) || wdata !== 12'h000) bad++;
        if (n == stop_at) return;
        n++;
        last = cyc;
      end
    end
    check("clr_writes", n, 4096);
    check("clr_bad_words", bad, 0);
    check("clr_busy_fall", cyc - last, 1);
    check("clr_wr0_after", wr0, 0);
    laddr = 4095;
    ldata = 0;
  endtask

  task automatic do_reset(input int stop_at);
    @(negedge clk);
    rst = 1;
    #1;
    check("rst_wr0", wr0, 0);
    check("rst_addr", address, 0);
    check("rst_wdata", wdata, 0);
    check("rst_busy", busy, 1);
    check("rst_cx", cursor_x, 32);
    check("rst_cy", cursor_y, 32);
    check("rst_ovf", overflow, 0);
    ex = 32; ey = 32; eidx = 0; epm = 0; eov = 0; laddr = 0; ldata = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    sweep(stop_at);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_req = 1;
    @(negedge clk);
    clear_req = 0;
    eov = 0;
    check("clr_busy", busy, 1);
    check("clr_ovf", overflow, 0);
    sweep(-1);
  endtask

  task automatic send(input int dx, input int dy, input logic [2:0] btn, input logic clr, input logic dup);
    int nx, ny;
    nx = clamp(ex + (dx >>> SS));
    ny = clamp(ey - (dy >>> SS));
    if (btn[2] && !epm) eidx = (eidx + 1) % 8;
    epm = btn[2];
    if (btn[1] | btn[0]) begin
      laddr = ny * 64 + nx;
      ldata = btn[1] ? 0 : int'(pal[eidx]);
    end
    if (dup) eov = 1;
    @(negedge clk);
    mouse_data_valid = 1;
    mouse_dx = 9'(dx);
    mouse_dy = 9'(dy);
    mouse_btn = btn;
    clear_req = clr;
    @(negedge clk);
    check("busy_upd", busy, 1);
    if (dup) begin
      mouse_dx = 9'($urandom);
      mouse_dy = 9'($urandom);
      mouse_btn = 3'($urandom);
    end else mouse_data_valid = 0;
    clear_req = 0;
    @(negedge clk);
    mouse_data_valid = 0;
    check("wr0", wr0, 32'(btn[1] | btn[0]));
    check("addr", address, laddr);
    check("wdata", wdata, ldata);
    check("cursor_x", cursor_x, nx);
    check("cursor_y", cursor_y, ny);
    @(negedge clk);
    check("busy_idle", busy, 0);
    check("wr0_idle", wr0, 0);
    check("ovf", overflow, eov);
    ex = nx;
    ey = ny;
  endtask

  initial begin
    do_reset(-1);
    send(5, 3, 3'b001, 0, 0);
    check("t2_addr", address, 1893);
    do_reset(-1);
    send(-100, -100, 3'b000, 0, 0);
    send(255, 0, 3'b000, 0, 0);
    check("t3_x", cursor_x, 63);
    send(0, 0, 3'b100, 0, 0);
    send(0, 0, 3'b101, 0, 0);
    send(0, 0, 3'b011, 0, 0);
    send(-7, 4, 3'b001, 0, 1);
    do_clear();
    for (int i = 0; i < 80; i++) begin
      int dx, dy;
      dx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 511)) - 256 : int'($urandom_range(0, 16)) - 8;
      dy = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 511)) - 256 : int'($urandom_range(0, 16)) - 8;
      send(dx, dy, 3'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    do_clear();
    send(1, 1, 3'b001, 0, 0);
    do_reset(2000);
    do_reset(-1);
    send(-3, 2, 3'b001, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
